ipif_initiator: RTL and testbench



---
 rtl/ipif_initiator.sv | 191 +++++++++++++++++++
 tb/tb_ipif_initiator.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ipif_initiator.sv
// IPIF bus master: one outstanding command at a time, decoded to one-hot CS/CE strobes,
// held until the matching ack or a timeout, then returned as a response.
module ipif_initiator #(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int N_CS               = 1,
  parameter int N_REG              = 2,
  parameter int TIMEOUT            = 255
) (
  input  logic                                clk,
  input  logic                                aresetn,
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic                                cmd_rnw,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]       cmd_addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       cmd_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]     cmd_be,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       rsp_rdata,
  output logic                                rsp_error,
  output logic                                rsp_timeout,
  output logic                                IPIF_Bus2IP_resetn,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]       IPIF_Bus2IP_Addr,
  output logic                                IPIF_Bus2IP_RNW,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0]     IPIF_Bus2IP_BE,
  output logic [N_CS-1:0]                     IPIF_Bus2IP_CS,
  output logic [N_CS*N_REG-1:0]               IPIF_Bus2IP_RdCE,
  output logic [N_CS*N_REG-1:0]               IPIF_Bus2IP_WrCE,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       IPIF_Bus2IP_Data,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       IPIF_IP2Bus_Data,
  input  logic                                IPIF_IP2Bus_WrAck,
  input  logic                                IPIF_IP2Bus_RdAck,
  input  logic                                IPIF_IP2Bus_Error
);

  localparam int AW   = C_S_AXI_ADDR_WIDTH;
  localparam int DW   = C_S_AXI_DATA_WIDTH;
  localparam int BW   = C_S_AXI_DATA_WIDTH / 8;
  localparam int N_CE = N_CS * N_REG;
  localparam int WW   = AW - 2;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              rnw_q, rnw_d;
  logic [BW-1:0]     be_q, be_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [N_CS-1:0]   cs_q, cs_d;
  logic [N_CE-1:0]   rdce_q, rdce_d;
  logic [N_CE-1:0]   wrce_q, wrce_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              tmo_q, tmo_d;
  logic [15:0]       timer_q, timer_d;
  logic              resetn_q;

  logic [WW-1:0]     w_addr;
  logic              dec_ok;
  logic [N_CE-1:0]   ce_hot;
  logic [N_CS-1:0]   cs_hot;
  logic              ack;
  logic              unused_addr_lsb;

  assign w_addr          = cmd_addr[AW-1:2];
  assign unused_addr_lsb = ^cmd_addr[1:0];
  assign dec_ok          = (w_addr < WW'(N_CE));
  assign ce_hot          = dec_ok ? (N_CE'(1) << w_addr) : '0;

  always_comb begin
    cs_hot = '0;
    for (int i = 0; i < N_CS; i++) begin
      cs_hot[i] = |ce_hot[i*N_REG +: N_REG];
    end
  end

  // Only the ack matching the latched direction ends the cycle.
  assign ack = rnw_q ? IPIF_IP2Bus_RdAck : IPIF_IP2Bus_WrAck;

  assign cmd_ready = aresetn && resetn_q && (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rnw_d   = rnw_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    cs_d    = cs_q;
    rdce_d  = rdce_q;
    wrce_d  = wrce_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    timer_d = timer_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d  = cmd_addr;
          rnw_d   = cmd_rnw;
          be_d    = cmd_be;
          wdata_d = cmd_wdata;
          rdata_d = '0;
          tmo_d   = 1'b0;
          timer_d = '0;
          if (dec_ok) begin
            cs_d    = cs_hot;
            rdce_d  = cmd_rnw ? ce_hot : '0;
            wrce_d  = cmd_rnw ? '0 : ce_hot;
            err_d   = 1'b0;
            state_d = ACCESS;
          end else begin
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      ACCESS: begin
        // An ack in the expiry cycle takes priority over the timeout.
        if (ack) begin
          cs_d    = '0;
          rdce_d  = '0;
          wrce_d  = '0;
          rdata_d = rnw_q ? IPIF_IP2Bus_Data : '0;
          err_d   = IPIF_IP2Bus_Error;
          state_d = RESP;
        end else if (timer_q == TMO_LAST) begin
          cs_d    = '0;
          rdce_d  = '0;
          wrce_d  = '0;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = RESP;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rnw_q    <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      cs_q     <= '0;
      rdce_q   <= '0;
      wrce_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
      timer_q  <= '0;
      resetn_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rnw_q    <= rnw_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      cs_q     <= cs_d;
      rdce_q   <= rdce_d;
      wrce_q   <= wrce_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
      timer_q  <= timer_d;
      resetn_q <= 1'b1;
    end
  end

  assign rsp_valid          = (state_q == RESP);
  assign rsp_rdata          = rdata_q;
  assign rsp_error          = err_q;
  assign rsp_timeout        = tmo_q;
  assign IPIF_Bus2IP_resetn = resetn_q;
  assign IPIF_Bus2IP_Addr   = addr_q;
  assign IPIF_Bus2IP_RNW    = rnw_q;
  assign IPIF_Bus2IP_BE     = be_q;
  assign IPIF_Bus2IP_CS     = cs_q;
  assign IPIF_Bus2IP_RdCE   = rdce_q;
  assign IPIF_Bus2IP_WrCE   = wrce_q;
  assign IPIF_Bus2IP_Data   = wdata_q;

endmodule

// File: tb/tb_ipif_initiator.sv
// Directed bench for ipif_initiator with two regions of two registers and an 8-cycle timeout.
module tb_ipif_initiator;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        cmd_valid, cmd_ready, cmd_rnw;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_be;
  logic        rsp_valid, rsp_ready, rsp_error, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        b_resetn, b_rnw;
  logic [31:0] b_addr, b_data;
  logic [3:0]  b_be;
  logic [1:0]  b_cs;
  logic [3:0]  b_rdce, b_wrce;
  logic [31:0] ip_data;
  logic        ip_wrack, ip_rdack, ip_error;

  int n_chk  = 0;
  int n_pass = 0;

  ipif_initiator #(
    .C_S_AXI_ADDR_WIDTH(32), .C_S_AXI_DATA_WIDTH(32),
    .N_CS(2), .N_REG(2), .TIMEOUT(8)
  ) dut (
    .clk(clk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
    .IPIF_Bus2IP_resetn(b_resetn), .IPIF_Bus2IP_Addr(b_addr),
    .IPIF_Bus2IP_RNW(b_rnw), .IPIF_Bus2IP_BE(b_be), .IPIF_Bus2IP_CS(b_cs),
    .IPIF_Bus2IP_RdCE(b_rdce), .IPIF_Bus2IP_WrCE(b_wrce),
    .IPIF_Bus2IP_Data(b_data), .IPIF_IP2Bus_Data(ip_data),
    .IPIF_IP2Bus_WrAck(ip_wrack), .IPIF_IP2Bus_RdAck(ip_rdack),
    .IPIF_IP2Bus_Error(ip_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rnw, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be);
    int n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    chk("issue_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_rnw = rnw; cmd_addr = a; cmd_wdata = d; cmd_be = be;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("consume_valid", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    int cnt;
    logic stable_ok;

    aresetn = 1'b0; cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_be = '0; rsp_ready = 1'b0; ip_data = '0; ip_wrack = 1'b0; ip_rdack = 1'b0;
    ip_error = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_strobes", {22'd0, b_cs, b_rdce, b_wrce}, 32'd0);
    chk("rst_bus_resetn", {31'd0, b_resetn}, 32'd0);
    chk("rst_addr", b_addr, 32'd0);
    aresetn = 1'b1;
    tick();
    chk("rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rel_bus_resetn", {31'd0, b_resetn}, 32'd1);

    // Write 0x12345678 to 0x4, WrAck three cycles after the strobe rises
    issue(1'b0, 32'h4, 32'h1234_5678, 4'hF);
    chk("wr_wrce", {28'd0, b_wrce}, 32'h2);
    chk("wr_cs", {30'd0, b_cs}, 32'h1);
    chk("wr_rdce", {28'd0, b_rdce}, 32'h0);
    chk("wr_data", b_data, 32'h1234_5678);
    chk("wr_addr", b_addr, 32'h4);
    chk("wr_be_rnw", {27'd0, b_be, b_rnw}, {27'd0, 4'hF, 1'b0});
    chk("wr_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    tick();
    tick();
    chk("wr_hold_wrce", {28'd0, b_wrce}, 32'h2);
    ip_wrack = 1'b1; ip_data = 32'hDEAD_BEEF;
    tick();
    ip_wrack = 1'b0;
    chk("wr_strobes_off", {22'd0, b_cs, b_rdce, b_wrce}, 32'd0);
    chk("wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("wr_rsp_status", {30'd0, rsp_error, rsp_timeout}, 32'd0);
    chk("wr_rsp_rdata", rsp_rdata, 32'd0);
    consume();
    chk("wr_ready_after", {31'd0, cmd_ready}, 32'd1);

    // Stray ack while idle produces nothing
    ip_rdack = 1'b1;
    tick();
    ip_rdack = 1'b0;
    tick();
    chk("idle_ack_ignored", {31'd0, rsp_valid}, 32'd0);

    // Read 0x0 with immediate RdAck carrying data and slave error
    issue(1'b1, 32'h0, 32'h0, 4'hF);
    chk("rd_rdce", {28'd0, b_rdce}, 32'h1);
    chk("rd_cs", {30'd0, b_cs}, 32'h1);
    ip_rdack = 1'b1; ip_data = 32'h00AB_CDEF; ip_error = 1'b1;
    tick();
    ip_rdack = 1'b0; ip_data = '0; ip_error = 1'b0;
    chk("rd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rd_rsp_rdata", rsp_rdata, 32'h00AB_CDEF);
    chk("rd_rsp_status", {30'd0, rsp_error, rsp_timeout}, 32'b10);
    consume();

    // Timeout: read 0x4 with no RdAck; a WrAck pulse mid-wait is ignored
    issue(1'b1, 32'h4, 32'h0, 4'hF);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (b_rdce == 4'h2) cnt++;
      if (rsp_valid) break;
      ip_wrack = (i == 2);
      tick();
    end
    ip_wrack = 1'b0;
    chk("tmo_rdce_cycles", cnt, 32'd8);
    chk("tmo_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("tmo_rsp_status", {30'd0, rsp_error, rsp_timeout}, 32'b11);
    chk("tmo_rsp_rdata", rsp_rdata, 32'd0);
    chk("tmo_strobes_off", {22'd0, b_cs, b_rdce, b_wrce}, 32'd0);
    consume();

    // Decode error: 0x10 is word 4, beyond four registers
    issue(1'b1, 32'h10, 32'h0, 4'hF);
    chk("dec_strobes", {22'd0, b_cs, b_rdce, b_wrce}, 32'd0);
    chk("dec_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("dec_rsp_status", {30'd0, rsp_error, rsp_timeout}, 32'b10);
    consume();
    chk("dec_strobes_after", {22'd0, b_cs, b_rdce, b_wrce}, 32'd0);

    // Write 0xC then a read of 0x8 presented while the response is stalled
    issue(1'b0, 32'hC, 32'hCAFE_F00D, 4'h3);
    chk("b2b_wrce", {28'd0, b_wrce}, 32'h8);
    chk("b2b_cs", {30'd0, b_cs}, 32'h2);
    ip_wrack = 1'b1;
    tick();
    ip_wrack = 1'b0;
    cmd_valid = 1'b1; cmd_rnw = 1'b1; cmd_addr = 32'h8; cmd_wdata = '0; cmd_be = 4'hF;
    stable_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!rsp_valid || rsp_error || cmd_ready || (b_rdce != 4'h0)) stable_ok = 1'b0;
      tick();
    end
    chk("b2b_stall_stable", {31'd0, stable_ok}, 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("b2b_gap_strobes", {22'd0, b_cs, b_rdce, b_wrce}, 32'd0);
    chk("b2b_gap_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk("b2b_rd_rdce", {28'd0, b_rdce}, 32'h4);
    chk("b2b_rd_cs", {30'd0, b_cs}, 32'h2);
    ip_rdack = 1'b1; ip_data = 32'h55AA_55AA;
    tick();
    ip_rdack = 1'b0; ip_data = '0;
    chk("b2b_rd_rdata", rsp_rdata, 32'h55AA_55AA);
    chk("b2b_rd_status", {30'd0, rsp_error, rsp_timeout}, 32'b00);
    consume();

    // Reset during ACCESS aborts the cycle with no response afterwards
    issue(1'b0, 32'h0, 32'h1111_2222, 4'hF);
    tick();
    chk("abort_pre_wrce", {28'd0, b_wrce}, 32'h1);
    aresetn = 1'b0;
    tick();
    chk("abort_strobes", {22'd0, b_cs, b_rdce, b_wrce}, 32'd0);
    chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("abort_bus_resetn", {31'd0, b_resetn}, 32'd0);
    aresetn = 1'b1;
    tick();
    ip_wrack = 1'b1;
    tick();
    ip_wrack = 1'b0;
    tick();
    chk("abort_no_stale_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("abort_ready", {31'd0, cmd_ready}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
